fu_wb_arbiter: RTL and testbench

Write-back arbiter directly downstream of the functional units (ALU, memory, multiplier, divider, jump). Holds each FU's completed result in a one-entry buffer, selects one buffered result per cycle by round-robin, and drives the single register-file write port. Reports per-FU retirement to the scoreboard so it can clear the destination-register reservation.

---
 rtl/fu_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_fu_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fu_wb_arbiter
// Brief    : Buffers one completed result per functional unit and retires one
//            per cycle to the register-file write port by round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module fu_wb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [NUM_FU*REG_W-1:0]  fu_rd,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        buf_full,
    output logic                     rf_we,
    output logic [REG_W-1:0]         rf_wa,
    output logic [DATA_W-1:0]        rf_wd,
    output logic [NUM_FU-1:0]        fu_ack,
    output logic                     ovf_err
);

    localparam int                PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_FU - 1);

    logic [NUM_FU-1:0] valid_q, valid_d;
    logic [REG_W-1:0]  rd_q   [NUM_FU];
    logic [REG_W-1:0]  rd_d   [NUM_FU];
    logic [DATA_W-1:0] data_q [NUM_FU];
    logic [DATA_W-1:0] data_d [NUM_FU];
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic [NUM_FU-1:0] fu_ack_q, fu_ack_d;
    logic              ovf_q, ovf_d;

    logic              gnt_valid;
    logic [PTR_W-1:0]  gnt_idx;
    logic [NUM_FU-1:0] gnt_oh;
    int                scan_idx;
    logic [PTR_W-1:0]  scan_sel;

    // Scan from the far end back toward ptr so the last hit is the first valid
    // buffer in round-robin order.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        scan_sel  = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_FU) begin
                scan_idx = scan_idx - NUM_FU;
            end
            scan_sel = PTR_W'(scan_idx);
            if (valid_q[scan_sel]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_sel;
            end
        end
        gnt_oh = gnt_valid ? (NUM_FU'(1) << gnt_idx) : '0;
    end

    // A buffer being drained this cycle can accept a new result; otherwise a
    // done pulse on an occupied buffer is dropped and flagged.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (gnt_oh[i]) begin
                valid_d[i] = 1'b0;
            end
            if (fu_done[i]) begin
                if (!valid_q[i] || gnt_oh[i]) begin
                    valid_d[i] = 1'b1;
                    rd_d[i]    = fu_rd[i*REG_W +: REG_W];
                    data_d[i]  = fu_data[i*DATA_W +: DATA_W];
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rf_we_d  = 1'b0;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;
        fu_ack_d = gnt_oh;
        ptr_d    = ptr_q;
        if (gnt_valid) begin
            rf_wa_d = rd_q[gnt_idx];
            rf_wd_d = data_q[gnt_idx];
            rf_we_d = (rd_q[gnt_idx] != '0);
            ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            ptr_q    <= '0;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            fu_ack_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
            rf_we_q  <= rf_we_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
            fu_ack_q <= fu_ack_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign buf_full = valid_q;
    assign rf_we    = rf_we_q;
    assign rf_wa    = rf_wa_q;
    assign rf_wd    = rf_wd_q;
    assign fu_ack   = fu_ack_q;
    assign ovf_err  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_wb_arbiter
// Brief    : Scoreboard bench for fu_wb_arbiter with a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_wb_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      fu_done;
    logic [N*RW-1:0]   fu_rd;
    logic [N*DW-1:0]   fu_data;
    logic [N-1:0]      buf_full;
    logic              rf_we;
    logic [RW-1:0]     rf_wa;
    logic [DW-1:0]     rf_wd;
    logic [N-1:0]      fu_ack;
    logic              ovf_err;

    fu_wb_arbiter #(.NUM_FU(N), .DATA_W(DW), .REG_W(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .fu_done  (fu_done),
        .fu_rd    (fu_rd),
        .fu_data  (fu_data),
        .buf_full (buf_full),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .fu_ack   (fu_ack),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            stamp;
        int            g;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t expq[$];

    // Reference state: buffered results, rotation start, sticky overflow.
    bit            m_valid [N];
    logic [RW-1:0] m_rd    [N];
    logic [DW-1:0] m_data  [N];
    int            m_ptr;
    bit            m_ovf;

    // Values each FU presents when it is pulsed.
    logic [RW-1:0] s_rd    [N];
    logic [DW-1:0] s_data  [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mgrant();
        for (int k = 0; k < N; k++) begin
            if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
        m_ovf = 1'b0;
    endtask

    // One clock cycle: check visible state, drive inputs, advance the model.
    task automatic step(input logic [N-1:0] d, input bit r);
        logic [N-1:0] mv;
        int g;
        @(negedge clk);
        for (int i = 0; i < N; i++) mv[i] = m_valid[i];
        check("buf_full", 64'(buf_full), 64'(mv));
        check("ovf_err", 64'(ovf_err), 64'(m_ovf));
        rst     = r;
        fu_done = d;
        for (int i = 0; i < N; i++) begin
            fu_rd[i*RW +: RW]   = s_rd[i];
            fu_data[i*DW +: DW] = s_data[i];
        end
        if (r) begin
            model_clear();
        end else begin
            g = mgrant();
            if (g >= 0) begin
                expq.push_back('{cyc + 1, g, m_rd[g], m_data[g]});
                m_valid[g] = 1'b0;
                m_ptr      = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (d[i]) begin
                    if (!m_valid[i]) begin
                        m_valid[i] = 1'b1;
                        m_rd[i]    = s_rd[i];
                        m_data[i]  = s_data[i];
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step('0, 1'b0);
    endtask

    task automatic reset_checks();
        @(posedge clk);
        #1;
        check("rst_rf_we", 64'(rf_we), 64'(0));
        check("rst_rf_wa", 64'(rf_wa), 64'(0));
        check("rst_rf_wd", 64'(rf_wd), 64'(0));
        check("rst_fu_ack", 64'(fu_ack), 64'(0));
        check("rst_ovf_err", 64'(ovf_err), 64'(0));
        check("rst_buf_full", 64'(buf_full), 64'(0));
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            s_rd[i]   = RW'($urandom_range(0, 31));
            s_data[i] = $urandom;
        end
    endtask

    // Monitor: every retirement must match the oldest expected one, in the
    // cycle the reference predicted.
    always @(negedge clk) begin
        exp_t e;
        if (fu_ack !== '0 && fu_ack !== 'x) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got fu_ack=%b expected none (cycle %0d)", fu_ack, cyc);
            end else begin
                e = expq.pop_front();
                check("ack_cycle", 64'(cyc), 64'(e.stamp));
                check("fu_ack", 64'(fu_ack), 64'(1) << e.g);
                check("rf_we", 64'(rf_we), 64'(e.rd != '0));
                check("rf_wa", 64'(rf_wa), 64'(e.rd));
                check("rf_wd", 64'(rf_wd), 64'(e.data));
            end
        end else if (cyc > 1) begin
            check("idle_rf_we", 64'(rf_we), 64'(0));
        end
    end

    initial begin
        int g;
        int v;
        logic [N-1:0] d;
        rst     = 1'b1;
        fu_done = '0;
        fu_rd   = '0;
        fu_data = '0;
        model_clear();
        for (int i = 0; i < N; i++) begin
            s_rd[i]   = '0;
            s_data[i] = '0;
            m_rd[i]   = '0;
            m_data[i] = '0;
        end

        step('0, 1'b1);
        reset_checks();

        // Single result on FU1.
        s_rd[1]   = 5'd5;
        s_data[1] = 32'hDEADBEEF;
        step(5'b00010, 1'b0);
        idle(4);

        // Simultaneous completions from a fresh pointer.
        step('0, 1'b1);
        s_rd[0] = 5'd1; s_data[0] = 32'hA0;
        s_rd[2] = 5'd2; s_data[2] = 32'hA2;
        s_rd[4] = 5'd3; s_data[4] = 32'hA4;
        step(5'b10101, 1'b0);
        idle(5);

        // Fairness: FU0 and FU3 refill whenever their buffer is free or draining.
        for (int c = 0; c < 20; c++) begin
            rand_payload();
            g = mgrant();
            d = '0;
            if (!m_valid[0] || g == 0) d[0] = 1'b1;
            if (!m_valid[3] || g == 3) d[3] = 1'b1;
            step(d, 1'b0);
        end
        idle(5);

        // Drain-and-refill on FU2.
        s_rd[2] = 5'd7; s_data[2] = 32'h11;
        step(5'b00100, 1'b0);
        s_data[2] = 32'h22;
        step(5'b00100, 1'b0);
        idle(4);

        // x0 destination: acked but not written.
        s_rd[0] = 5'd0; s_data[0] = 32'h7;
        step(5'b00001, 1'b0);
        idle(3);

        // Overflow on a buffer that is full and not granted.
        rand_payload();
        for (int i = 0; i < N; i++) if (s_rd[i] == '0) s_rd[i] = 5'd9;
        step(5'b11111, 1'b0);
        g = mgrant();
        v = (g + 2) % N;
        s_data[v] = 32'hBAD0BAD0;
        step(N'(1) << v, 1'b0);
        idle(8);

        // Reset mid-operation with three buffers full and done pulses on the reset edge.
        rand_payload();
        step(5'b00111, 1'b0);
        step(5'b11111, 1'b1);
        reset_checks();
        idle(6);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            rand_payload();
            step(N'($urandom) & N'($urandom), 1'b0);
        end
        idle(10);

        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_writes: got %0d outstanding expected 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
